ps2_rx_sched: RTL and testbench

Sequencing controller for the PS/2 byte receiver. Repeatedly arms the receiver with single-cycle `start` pulses, classifies each completed reception as good byte, parity/stop error or idle timeout, and folds scan-code prefixes (E0 extended, F0 break) into complete key events. Events go into a small FIFO drained by the keyboard logic. Sits between the receiver and the key-matrix/HID layer, in the receiver's `clock_quarter` domain.

---
 rtl/ps2_rx_sched.sv | 159 +++++++++++++++
 tb/tb_ps2_rx_sched.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_sched.sv
// PS/2 receive sequencer: arms the byte receiver, folds E0/F0 prefixes into key events, queues them.
// Optional PS2_ERR_CNT_EN: implements the saturating discarded-frame counter on err_cnt.
module ps2_rx_sched #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned POLL_GAP   = 8
) (
   input  logic       clock_quarter,
   input  logic       reset,
   input  logic       rx_ready,
   input  logic       rx_faild,
   input  logic       rx_finish,
   input  logic [7:0] rx_data,
   output logic       rx_start,
   output logic       ev_valid,
   output logic [9:0] ev_data,
   input  logic       ev_ready,
   output logic [7:0] err_cnt,
   output logic       busy
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned EV_W  = 10;

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_GAP} state_t;

   state_t            state_q, state_d;
   logic              rx_start_d, busy_d, ev_valid_d;
   logic [EV_W-1:0]   ev_data_d, push_data;
   logic [7:0]        gap_q, gap_d;
   logic              ext_q, ext_d, brk_q, brk_d, err_flag_q, err_flag_d;
   logic [PTR_W-1:0]  wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_left;
   logic              push, pop, err_inc;
   logic [EV_W-1:0]   mem [FIFO_DEPTH];

   assign push_data = {brk_q, ext_q, rx_data};
   assign pop       = ev_valid & ev_ready;

   // Next-state, reception classification and FIFO bookkeeping
   always_comb begin
      state_d    = state_q;
      rx_start_d = 1'b0;
      gap_d      = gap_q;
      ext_d      = ext_q;
      brk_d      = brk_q;
      err_flag_d = err_flag_q;
      push       = 1'b0;
      err_inc    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cnt_q < CNT_W'(FIFO_DEPTH)) begin
               state_d    = S_ARM;
               rx_start_d = rx_ready;
            end
         end
         S_ARM: begin
            // The pulse is issued from ARM; once it is on the wire, move on.
            if (rx_start) state_d = S_WAIT;
            else          rx_start_d = rx_ready;
         end
         S_WAIT: begin
            if (rx_finish) begin
               state_d = S_GAP;
               gap_d   = 8'd0;
               if (rx_faild) begin
                  // idle timeout: nothing received, nothing changes
               end else if (err_flag_q) begin
                  err_flag_d = 1'b0;
                  ext_d      = 1'b0;
                  brk_d      = 1'b0;
                  err_inc    = 1'b1;
               end else if (rx_data == 8'hE0) begin
                  ext_d = 1'b1;
               end else if (rx_data == 8'hF0) begin
                  brk_d = 1'b1;
               end else begin
                  push  = 1'b1;
                  ext_d = 1'b0;
                  brk_d = 1'b0;
               end
            end else if (rx_faild) begin
               err_flag_d = 1'b1;
            end
         end
         S_GAP: begin
            if (gap_q == 8'(POLL_GAP - 1)) state_d = S_IDLE;
            else                          gap_d   = gap_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase

      busy_d   = (state_d != S_IDLE);
      wr_d     = wr_q + PTR_W'(push);
      rd_d     = rd_q + PTR_W'(pop);
      cnt_d    = cnt_q + CNT_W'(push) - CNT_W'(pop);
      cnt_left = cnt_q - CNT_W'(pop);

      // Registered head: bypass the write when the FIFO is effectively empty
      ev_valid_d = (cnt_d != '0);
      ev_data_d  = '0;
      if (cnt_d != '0) begin
         if (cnt_left == '0) ev_data_d = push_data;
         else                ev_data_d = mem[rd_d];
      end
   end

   always_ff @(posedge clock_quarter) begin
      if (reset) begin
         state_q    <= S_IDLE;
         rx_start   <= 1'b0;
         busy       <= 1'b0;
         ev_valid   <= 1'b0;
         ev_data    <= '0;
         gap_q      <= '0;
         ext_q      <= 1'b0;
         brk_q      <= 1'b0;
         err_flag_q <= 1'b0;
         wr_q       <= '0;
         rd_q       <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         rx_start   <= rx_start_d;
         busy       <= busy_d;
         ev_valid   <= ev_valid_d;
         ev_data    <= ev_data_d;
         gap_q      <= gap_d;
         ext_q      <= ext_d;
         brk_q      <= brk_d;
         err_flag_q <= err_flag_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   always_ff @(posedge clock_quarter) begin
      if (push) mem[wr_q] <= push_data;
   end

`ifdef PS2_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clock_quarter) begin
      if (reset)                             err_cnt_q <= 8'd0;
      else if (err_inc && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_err_inc;

   assign unused_err_inc = err_inc;
   assign err_cnt        = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_rx_sched.sv
// Bench for ps2_rx_sched: behavioural receiver driven from a frame queue, event scoreboard, corner sequences.
module tb_ps2_rx_sched;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned GAP   = 8;
   localparam logic [1:0] K_GOOD = 2'd0, K_CORRUPT = 2'd1, K_TMO = 2'd2;
`ifdef PS2_ERR_CNT_EN
   localparam logic [7:0] EXP_ERR = 8'd1;
`else
   localparam logic [7:0] EXP_ERR = 8'd0;
`endif

   typedef struct packed {
      logic [7:0] data;
      logic [1:0] kind;
   } frame_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] kind;
      bit         has_ev;
      logic [9:0] ev;
   } vec_t;

   logic       clock_quarter = 1'b0;
   logic       reset, rx_ready, rx_faild, rx_finish, ev_ready;
   logic [7:0] rx_data, err_cnt;
   logic       rx_start, ev_valid, busy;
   logic [9:0] ev_data;

   int checks = 0, errors = 0;
   int cyc = 0, n_start = 0, n_fin = 0, last_fin = 0;
   bit have_fin = 0, gap_chk = 0;
   frame_t     frame_q[$];
   logic [9:0] exp_q[$];
   vec_t       vecs[14];

   ps2_rx_sched #(.FIFO_DEPTH(DEPTH), .POLL_GAP(GAP)) dut (
      .clock_quarter(clock_quarter), .reset(reset),
      .rx_ready(rx_ready), .rx_faild(rx_faild), .rx_finish(rx_finish), .rx_data(rx_data),
      .rx_start(rx_start), .ev_valid(ev_valid), .ev_data(ev_data), .ev_ready(ev_ready),
      .err_cnt(err_cnt), .busy(busy)
   );

   always #5 clock_quarter = ~clock_quarter;
   always @(posedge clock_quarter) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic wait_fin(input int target);
      for (int i = 0; i < 400; i++) begin
         if (n_fin >= target) break;
         @(negedge clock_quarter);
      end
      check("fin_wait", 32'(n_fin >= target), 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 400; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clock_quarter);
      end
      check("drain", 32'(exp_q.size()), 32'd0);
   endtask

   // Receiver model: answers each start pulse with the next queued frame
   initial begin
      frame_t f;
      rx_ready = 1'b1; rx_finish = 1'b0; rx_faild = 1'b0; rx_data = 8'h00;
      forever begin
         @(negedge clock_quarter);
         if (!reset && rx_start) begin
            n_start++;
            if (gap_chk && have_fin) check("start_gap", 32'(cyc - last_fin), 32'(GAP + 2));
            @(posedge clock_quarter); #1;
            rx_ready = 1'b0;
            while (frame_q.size() == 0 && !reset) begin
               @(posedge clock_quarter); #1;
            end
            if (!reset) begin
               f = frame_q.pop_front();
               repeat (2) begin @(posedge clock_quarter); #1; end
               if (f.kind == K_CORRUPT) begin
                  rx_faild = 1'b1;
                  @(posedge clock_quarter); #1;
                  rx_faild = 1'b0;
               end
               @(posedge clock_quarter); #1;
               rx_finish = 1'b1;
               rx_faild  = (f.kind == K_TMO);
               rx_data   = f.data;
               last_fin  = cyc;
               have_fin  = 1'b1;
               n_fin++;
               @(posedge clock_quarter); #1;
               rx_finish = 1'b0;
               rx_faild  = 1'b0;
            end
            rx_ready = 1'b1;
         end
      end
   end

   // Scoreboard consumer and start-pulse protocol monitor
   always @(negedge clock_quarter) begin
      if (!reset) begin
         if (rx_start) check("start_ready", 32'(rx_ready), 32'd1);
         if (ev_valid && ev_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL ev_extra: got %0h expected no event", ev_data);
            end else begin
               check("ev_data", 32'(ev_data), 32'(exp_q.pop_front()));
            end
         end
      end
   end

   initial begin
      int s0, f0;
      vecs[0]  = '{8'h1C, K_GOOD,    1'b1, 10'h01C};
      vecs[1]  = '{8'hE0, K_GOOD,    1'b0, 10'h000};
      vecs[2]  = '{8'hF0, K_GOOD,    1'b0, 10'h000};
      vecs[3]  = '{8'h75, K_GOOD,    1'b1, 10'h375};
      vecs[4]  = '{8'hE0, K_GOOD,    1'b0, 10'h000};
      vecs[5]  = '{8'h74, K_CORRUPT, 1'b0, 10'h000};
      vecs[6]  = '{8'h74, K_GOOD,    1'b1, 10'h074};
      vecs[7]  = '{8'hF0, K_GOOD,    1'b0, 10'h000};
      vecs[8]  = '{8'h00, K_TMO,     1'b0, 10'h000};
      vecs[9]  = '{8'h1C, K_GOOD,    1'b1, 10'h21C};
      vecs[10] = '{8'hF0, K_GOOD,    1'b0, 10'h000};
      vecs[11] = '{8'h12, K_GOOD,    1'b1, 10'h212};
      vecs[12] = '{8'hE0, K_GOOD,    1'b0, 10'h000};
      vecs[13] = '{8'h70, K_GOOD,    1'b1, 10'h170};

      reset = 1'b1; ev_ready = 1'b0;
      repeat (3) @(posedge clock_quarter);
      #1 reset = 1'b0;
      @(negedge clock_quarter);
      check("rst_rx_start", 32'(rx_start), 32'd0);
      check("rst_ev_valid", 32'(ev_valid), 32'd0);
      check("rst_ev_data",  32'(ev_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_err_cnt",  32'(err_cnt),  32'd0);

      // Table of frames with free-running consumer
      @(posedge clock_quarter); #1;
      ev_ready = 1'b1;
      gap_chk  = 1'b1;
      for (int i = 0; i < 14; i++) begin
         frame_q.push_back('{data: vecs[i].data, kind: vecs[i].kind});
         if (vecs[i].has_ev) exp_q.push_back(vecs[i].ev);
         wait_fin(n_fin + 1);
         @(negedge clock_quarter);
         check("ev_valid_n1", 32'(ev_valid), 32'(vecs[i].has_ev));
         if (vecs[i].has_ev) check("ev_head_n1", 32'(ev_data), 32'(vecs[i].ev));
      end
      gap_chk = 1'b0;
      repeat (30) @(negedge clock_quarter);
      check("table_drained", 32'(exp_q.size()), 32'd0);
      check("err_cnt", 32'(err_cnt), 32'(EXP_ERR));
      check("busy_armed", 32'(busy), 32'd1);

      // Back-pressure: five keys into a four-entry FIFO
      @(posedge clock_quarter); #1;
      ev_ready = 1'b0;
      s0 = n_start; f0 = n_fin;
      for (int k = 0; k < 5; k++) begin
         frame_q.push_back('{data: 8'(8'h11 + k), kind: K_GOOD});
         exp_q.push_back(10'(10'h011 + k));
      end
      repeat (200) @(negedge clock_quarter);
      check("full_fins",   32'(n_fin - f0),   32'd4);
      check("full_starts", 32'(n_start - s0), 32'd3);
      check("full_pend",   32'(frame_q.size()), 32'd1);
      check("full_valid",  32'(ev_valid), 32'd1);
      check("full_head",   32'(ev_data), 32'h011);
      @(posedge clock_quarter); #1;
      ev_ready = 1'b1;
      @(posedge clock_quarter); #1;
      ev_ready = 1'b0;
      @(negedge clock_quarter);
      check("head_after_pop", 32'(ev_data), 32'h012);
      wait_fin(f0 + 5);
      @(posedge clock_quarter); #1;
      ev_ready = 1'b1;
      wait_drain();

      // Reset while waiting for a frame with two events queued
      @(posedge clock_quarter); #1;
      ev_ready = 1'b0;
      f0 = n_fin;
      frame_q.push_back('{data: 8'h21, kind: K_GOOD});
      frame_q.push_back('{data: 8'h22, kind: K_GOOD});
      wait_fin(f0 + 2);
      repeat (20) @(negedge clock_quarter);
      check("pre_rst_busy",  32'(busy),     32'd1);
      check("pre_rst_valid", 32'(ev_valid), 32'd1);
      check("pre_rst_head",  32'(ev_data),  32'h021);
      @(posedge clock_quarter); #1;
      reset = 1'b1;
      @(posedge clock_quarter);
      @(negedge clock_quarter);
      check("mid_rst_valid", 32'(ev_valid), 32'd0);
      check("mid_rst_busy",  32'(busy),     32'd0);
      check("mid_rst_start", 32'(rx_start), 32'd0);
      check("mid_rst_err",   32'(err_cnt),  32'd0);
      @(posedge clock_quarter); #1;
      reset    = 1'b0;
      ev_ready = 1'b1;
      frame_q.push_back('{data: 8'hE0, kind: K_GOOD});
      frame_q.push_back('{data: 8'h6B, kind: K_GOOD});
      exp_q.push_back(10'h16B);
      frame_q.push_back('{data: 8'h1C, kind: K_GOOD});
      exp_q.push_back(10'h01C);
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
